// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encodings and parameter defaults.
package pipe_hazard_ctrl_pkg;

    localparam int HZ_MD_TIMEOUT_DEF  = 64;
    localparam int HZ_STALL_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MD_WAIT  = 2'd1,
        HZ_LSU_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hz_loaduse_detect.sv
// Combinational source/destination compare for the load-use hazard.
// Kept generic so the forwarding unit can reuse the same match logic.
module hz_loaduse_detect (
    input  logic [4:0] src1_i,
    input  logic [4:0] src2_i,
    input  logic [1:0] src_en_i,
    input  logic [4:0] dst_i,
    input  logic       is_load_i,
    input  logic       valid_i,
    output logic       hazard_o
);

    logic src1_hit;
    logic src2_hit;
    logic dst_live;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign dst_live = valid_i && is_load_i && (dst_i != 5'd0);
    assign src1_hit = src_en_i[0] && (src1_i == dst_i);
    assign src2_hit = src_en_i[1] && (src2_i == dst_i);
    assign hazard_o = dst_live && (src1_hit || src2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core: turns hazard sources
// into cumulative pause/clear controls and keeps a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT  = HZ_MD_TIMEOUT_DEF,
    parameter int STALL_CNT_W = HZ_STALL_CNT_W_DEF
) (
    input  logic                   core_clk,
    input  logic                   core_rst_n,
    input  logic [4:0]             dfu_src1,
    input  logic [4:0]             dfu_src2,
    input  logic [1:0]             dfu_src_en,
    input  logic [4:0]             de_dst,
    input  logic                   de_is_load,
    input  logic                   de_valid,
    input  logic                   md_start,
    input  logic                   md_done,
    input  logic                   lsu_req,
    input  logic                   lsu_resp,
    input  logic                   br_taken_el,
    input  logic                   flush_req,
    output logic                   pause_ifu,
    output logic                   pause_dfu,
    output logic                   pause_exu,
    output logic                   pause_lsu,
    output logic                   pause_wbu,
    output logic                   clear_id,
    output logic                   clear_de,
    output logic                   clear_el,
    output logic                   clear_lw,
    output logic                   clear_all,
    output logic                   clear_before_lw,
    output logic                   id_clk_en,
    output logic                   de_clk_en,
    output logic                   el_clk_en,
    output logic                   lw_clk_en,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   md_timeout,
    output hz_state_e              dbg_state_o
);

    localparam int MD_CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

    hz_state_e              state_q, state_d;
    logic [MD_CNT_W-1:0]    md_cnt_q, md_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   md_timeout_q, md_timeout_d;
    logic                   clk_en_q;

    logic lu_hazard;
    logic lsu_stall, md_stall, lu_stall, do_flush, do_branch, to_hit;

    hz_loaduse_detect u_loaduse (
        .src1_i    (dfu_src1),
        .src2_i    (dfu_src2),
        .src_en_i  (dfu_src_en),
        .dst_i     (de_dst),
        .is_load_i (de_is_load),
        .valid_i   (de_valid),
        .hazard_o  (lu_hazard)
    );

    // Inputs are ignored while reset is held so the controls stay quiet.
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = '0;
        lsu_stall = 1'b0;
        md_stall  = 1'b0;
        lu_stall  = 1'b0;
        do_flush  = 1'b0;
        do_branch = 1'b0;
        to_hit    = 1'b0;
        if (core_rst_n) begin
            if (flush_req) begin
                do_flush = 1'b1;
                state_d  = HZ_RUN;
            end else begin
                case (state_q)
                    HZ_RUN: begin
                        // An LSU stall holds a (nominally impossible) branch in EL.
                        if (lsu_req && !lsu_resp) begin
                            lsu_stall = 1'b1;
                            state_d   = HZ_LSU_WAIT;
                        end else if (br_taken_el) begin
                            do_branch = 1'b1;
                        end else if (md_start && de_valid && !md_done) begin
                            md_stall = 1'b1;
                            state_d  = HZ_MD_WAIT;
                        end else if (lu_hazard) begin
                            lu_stall = 1'b1;
                        end
                    end
                    HZ_LSU_WAIT: begin
                        if (lsu_resp) begin
                            state_d = HZ_RUN;
                        end else begin
                            lsu_stall = 1'b1;
                        end
                    end
                    HZ_MD_WAIT: begin
                        if (md_done) begin
                            state_d = HZ_RUN;
                        end else begin
                            md_stall = 1'b1;
                            if (md_cnt_q == MD_LAST) begin
                                to_hit  = 1'b1;
                                state_d = HZ_RUN;
                            end else begin
                                md_cnt_d = md_cnt_q + MD_CNT_W'(1);
                            end
                        end
                    end
                    default: state_d = HZ_RUN;
                endcase
            end
        end
    end

    // Pauses are built up stage by stage so a later-stage pause always implies earlier ones.
    assign pause_lsu       = lsu_stall;
    assign pause_exu       = lsu_stall | md_stall;
    assign pause_dfu       = lsu_stall | md_stall | lu_stall;
    assign pause_ifu       = pause_dfu;
    assign pause_wbu       = 1'b0;
    assign clear_id        = 1'b0;
    assign clear_de        = lu_stall;
    assign clear_el        = md_stall;
    assign clear_lw        = lsu_stall;
    assign clear_all       = do_flush;
    assign clear_before_lw = do_branch;

    assign md_timeout_d = md_timeout_q | to_hit;
    assign stall_cnt_d  = (pause_ifu && (stall_cnt_q != '1)) ? stall_cnt_q + STALL_CNT_W'(1)
                                                             : stall_cnt_q;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q      <= HZ_RUN;
            md_cnt_q     <= '0;
            stall_cnt_q  <= '0;
            md_timeout_q <= 1'b0;
            clk_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            md_timeout_q <= md_timeout_d;
            clk_en_q     <= 1'b1;
        end
    end

    assign id_clk_en   = clk_en_q;
    assign de_clk_en   = clk_en_q;
    assign el_clk_en   = clk_en_q;
    assign lw_clk_en   = clk_en_q;
    assign stall_cnt   = stall_cnt_q;
    assign md_timeout  = md_timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-parameter instance plus a
// short-timeout instance sharing the same stimulus.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int CW = 16;

    logic       core_clk, core_rst_n;
    logic [4:0] dfu_src1, dfu_src2, de_dst;
    logic [1:0] dfu_src_en;
    logic       de_is_load, de_valid, md_start, md_done;
    logic       lsu_req, lsu_resp, br_taken_el, flush_req;

    logic          pause_ifu, pause_dfu, pause_exu, pause_lsu, pause_wbu;
    logic          clear_id, clear_de, clear_el, clear_lw, clear_all, clear_before_lw;
    logic          id_clk_en, de_clk_en, el_clk_en, lw_clk_en, md_timeout;
    logic [CW-1:0] stall_cnt;
    hz_state_e     dbg_state;

    logic          t_pause_ifu, t_pause_dfu, t_pause_exu, t_pause_lsu, t_pause_wbu;
    logic          t_clear_id, t_clear_de, t_clear_el, t_clear_lw, t_clear_all, t_clear_before_lw;
    logic          t_id_clk_en, t_de_clk_en, t_el_clk_en, t_lw_clk_en, t_md_timeout;
    logic [CW-1:0] t_stall_cnt;
    hz_state_e     t_dbg_state;

    logic [4:0] pv, t_pv;
    logic [5:0] cv;
    logic [3:0] ev;
    assign pv   = {pause_ifu, pause_dfu, pause_exu, pause_lsu, pause_wbu};
    assign t_pv = {t_pause_ifu, t_pause_dfu, t_pause_exu, t_pause_lsu, t_pause_wbu};
    assign cv   = {clear_id, clear_de, clear_el, clear_lw, clear_all, clear_before_lw};
    assign ev   = {id_clk_en, de_clk_en, el_clk_en, lw_clk_en};

    int n_chk = 0;
    int n_err = 0;
    int exp_stall = 0;

    pipe_hazard_ctrl dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .dfu_src1(dfu_src1), .dfu_src2(dfu_src2), .dfu_src_en(dfu_src_en),
        .de_dst(de_dst), .de_is_load(de_is_load), .de_valid(de_valid),
        .md_start(md_start), .md_done(md_done), .lsu_req(lsu_req), .lsu_resp(lsu_resp),
        .br_taken_el(br_taken_el), .flush_req(flush_req),
        .pause_ifu(pause_ifu), .pause_dfu(pause_dfu), .pause_exu(pause_exu),
        .pause_lsu(pause_lsu), .pause_wbu(pause_wbu),
        .clear_id(clear_id), .clear_de(clear_de), .clear_el(clear_el), .clear_lw(clear_lw),
        .clear_all(clear_all), .clear_before_lw(clear_before_lw),
        .id_clk_en(id_clk_en), .de_clk_en(de_clk_en), .el_clk_en(el_clk_en), .lw_clk_en(lw_clk_en),
        .stall_cnt(stall_cnt), .md_timeout(md_timeout), .dbg_state_o(dbg_state)
    );

    pipe_hazard_ctrl #(.MD_TIMEOUT(8), .STALL_CNT_W(CW)) dut_to (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .dfu_src1(dfu_src1), .dfu_src2(dfu_src2), .dfu_src_en(dfu_src_en),
        .de_dst(de_dst), .de_is_load(de_is_load), .de_valid(de_valid),
        .md_start(md_start), .md_done(md_done), .lsu_req(lsu_req), .lsu_resp(lsu_resp),
        .br_taken_el(br_taken_el), .flush_req(flush_req),
        .pause_ifu(t_pause_ifu), .pause_dfu(t_pause_dfu), .pause_exu(t_pause_exu),
        .pause_lsu(t_pause_lsu), .pause_wbu(t_pause_wbu),
        .clear_id(t_clear_id), .clear_de(t_clear_de), .clear_el(t_clear_el), .clear_lw(t_clear_lw),
        .clear_all(t_clear_all), .clear_before_lw(t_clear_before_lw),
        .id_clk_en(t_id_clk_en), .de_clk_en(t_de_clk_en), .el_clk_en(t_el_clk_en), .lw_clk_en(t_lw_clk_en),
        .stall_cnt(t_stall_cnt), .md_timeout(t_md_timeout), .dbg_state_o(t_dbg_state)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic clr_inputs();
        dfu_src1 = '0; dfu_src2 = '0; dfu_src_en = '0; de_dst = '0;
        de_is_load = 0; de_valid = 0; md_start = 0; md_done = 0;
        lsu_req = 0; lsu_resp = 0; br_taken_el = 0; flush_req = 0;
    endtask

    task automatic do_reset();
        core_rst_n = 1'b0;
        clr_inputs();
        @(negedge core_clk);
        @(negedge core_clk);
        core_rst_n = 1'b1;
        exp_stall = 0;
    endtask

    task automatic test_reset();
        core_rst_n = 1'b0;
        clr_inputs();
        lsu_req = 1; md_start = 1; de_valid = 1; br_taken_el = 1;
        @(negedge core_clk);
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl pause=%b clear=%b want 0/0", pv, cv);
        end
        n_chk++;
        if (ev !== 4'b0) begin n_err++; $display("FAIL reset_clk_en got=%b want=0000", ev); end
        n_chk++;
        if (stall_cnt !== '0 || md_timeout !== 1'b0) begin
            n_err++; $display("FAIL reset_cnt stall=%0d to=%b want 0/0", stall_cnt, md_timeout);
        end
        n_chk++;
        if (dbg_state !== HZ_RUN) begin n_err++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, HZ_RUN); end
        clr_inputs();
        @(negedge core_clk);
        core_rst_n = 1'b1;
        #1;
        n_chk++;
        if (ev !== 4'b0) begin n_err++; $display("FAIL clk_en_pre_edge got=%b want=0000", ev); end
        @(negedge core_clk);
        #1;
        n_chk++;
        if (ev !== 4'hf) begin n_err++; $display("FAIL clk_en_post_edge got=%b want=1111", ev); end
        exp_stall = 0;
    endtask

    task automatic test_loaduse();
        // {valid, load, dst, src1, src2, en, hazard}
        logic [19:0] vec [6];
        vec[0] = {1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 1'b1};
        vec[1] = {1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 2'b01, 1'b0};
        vec[2] = {1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 2'b01, 1'b0};
        vec[3] = {1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 2'b10, 1'b1};
        vec[4] = {1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0};
        vec[5] = {1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 2'b11, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge core_clk);
            {de_valid, de_is_load, de_dst, dfu_src1, dfu_src2, dfu_src_en} = vec[i][19:1];
            #1;
            n_chk++;
            if (vec[i][0]) begin
                if (pv !== 5'b11000 || cv !== 6'b010000) begin
                    n_err++; $display("FAIL loaduse_hit v=%0d pause=%b clear=%b want 11000/010000", i, pv, cv);
                end
                exp_stall++;
            end else if (pv !== 5'b0 || cv !== 6'b0) begin
                n_err++; $display("FAIL loaduse_quiet v=%0d pause=%b clear=%b want 0/0", i, pv, cv);
            end
            if (i == 1) begin
                n_chk++;
                if (stall_cnt !== CW'(1)) begin n_err++; $display("FAIL loaduse_stall_cnt got=%0d want=1", stall_cnt); end
            end
        end
        @(negedge core_clk);
        clr_inputs();
        #1;
        n_chk++;
        if (stall_cnt !== CW'(exp_stall)) begin
            n_err++; $display("FAIL loaduse_stall_total got=%0d want=%0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_md();
        do_reset();
        @(negedge core_clk);
        de_valid = 1; md_start = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) md_start = 0;
            #1;
            n_chk++;
            if (pv !== 5'b11100 || cv !== 6'b001000) begin
                n_err++; $display("FAIL md_wait cyc=%0d pause=%b clear=%b want 11100/001000", i, pv, cv);
            end
            if (i == 1) begin
                n_chk++;
                if (dbg_state !== HZ_MD_WAIT) begin n_err++; $display("FAIL md_state got=%0d want=%0d", dbg_state, HZ_MD_WAIT); end
            end
            @(negedge core_clk);
        end
        md_done = 1;
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b0) begin n_err++; $display("FAIL md_done pause=%b clear=%b want 0/0", pv, cv); end
        @(negedge core_clk);
        md_done = 0; de_valid = 0;
        #1;
        n_chk++;
        if (dbg_state !== HZ_RUN || stall_cnt !== CW'(10)) begin
            n_err++; $display("FAIL md_end state=%0d stall=%0d want %0d/10", dbg_state, stall_cnt, HZ_RUN);
        end
        @(negedge core_clk);
        md_start = 1; de_valid = 1; md_done = 1;
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b0) begin n_err++; $display("FAIL md_same_cycle pause=%b clear=%b want 0/0", pv, cv); end
        @(negedge core_clk);
        clr_inputs();
        #1;
        n_chk++;
        if (dbg_state !== HZ_RUN) begin n_err++; $display("FAIL md_same_cycle_state got=%0d want=%0d", dbg_state, HZ_RUN); end
    endtask

    task automatic test_lsu();
        do_reset();
        @(negedge core_clk);
        lsu_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (pv !== 5'b11110 || cv !== 6'b000100) begin
                n_err++; $display("FAIL lsu_wait cyc=%0d pause=%b clear=%b want 11110/000100", i, pv, cv);
            end
            @(negedge core_clk);
        end
        lsu_resp = 1;
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b0) begin n_err++; $display("FAIL lsu_resp pause=%b clear=%b want 0/0", pv, cv); end
        @(negedge core_clk);
        lsu_req = 0; lsu_resp = 0;
        #1;
        n_chk++;
        if (dbg_state !== HZ_RUN || stall_cnt !== CW'(3)) begin
            n_err++; $display("FAIL lsu_end state=%0d stall=%0d want %0d/3", dbg_state, stall_cnt, HZ_RUN);
        end
        @(negedge core_clk);
        lsu_req = 1; lsu_resp = 1;
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b0) begin n_err++; $display("FAIL lsu_same_cycle pause=%b clear=%b want 0/0", pv, cv); end
        @(negedge core_clk);
        clr_inputs();
        #1;
        n_chk++;
        if (dbg_state !== HZ_RUN || stall_cnt !== CW'(3)) begin
            n_err++; $display("FAIL lsu_same_cycle_end state=%0d stall=%0d want %0d/3", dbg_state, stall_cnt, HZ_RUN);
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        @(negedge core_clk);
        br_taken_el = 1;
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b000001) begin n_err++; $display("FAIL branch pause=%b clear=%b want 0/000001", pv, cv); end
        @(negedge core_clk);
        br_taken_el = 0;
        #1;
        n_chk++;
        if (cv !== 6'b0) begin n_err++; $display("FAIL branch_after clear=%b want 000000", cv); end
        @(negedge core_clk);
        br_taken_el = 1; lsu_req = 1;
        #1;
        n_chk++;
        if (pv !== 5'b11110 || cv !== 6'b000100) begin
            n_err++; $display("FAIL branch_vs_lsu pause=%b clear=%b want 11110/000100", pv, cv);
        end
        @(negedge core_clk);
        br_taken_el = 0; flush_req = 1;
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b000010) begin n_err++; $display("FAIL flush_lsu pause=%b clear=%b want 0/000010", pv, cv); end
        @(negedge core_clk);
        flush_req = 0; lsu_req = 0; lsu_resp = 1;
        #1;
        n_chk++;
        if (dbg_state !== HZ_RUN || pv !== 5'b0 || cv !== 6'b0) begin
            n_err++; $display("FAIL flush_lsu_after state=%0d pause=%b clear=%b want %0d/0/0", dbg_state, pv, cv, HZ_RUN);
        end
        @(negedge core_clk);
        lsu_resp = 0; md_start = 1; de_valid = 1;
        @(negedge core_clk);
        md_start = 0; flush_req = 1;
        #1;
        n_chk++;
        if (pv !== 5'b0 || cv !== 6'b000010) begin n_err++; $display("FAIL flush_md pause=%b clear=%b want 0/000010", pv, cv); end
        @(negedge core_clk);
        clr_inputs(); md_done = 1;
        #1;
        n_chk++;
        if (dbg_state !== HZ_RUN || stall_cnt !== CW'(2)) begin
            n_err++; $display("FAIL flush_md_after state=%0d stall=%0d want %0d/2", dbg_state, stall_cnt, HZ_RUN);
        end
        @(negedge core_clk);
        clr_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge core_clk);
        md_start = 1; de_valid = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == 1) md_start = 0;
            #1;
            if (i >= 1) begin
                n_chk++;
                if (t_dbg_state !== HZ_MD_WAIT || t_md_timeout !== 1'b0 || t_pv !== 5'b11100) begin
                    n_err++; $display("FAIL timeout_wait cyc=%0d state=%0d to=%b pause=%b want %0d/0/11100",
                                      i, t_dbg_state, t_md_timeout, t_pv, HZ_MD_WAIT);
                end
            end
            @(negedge core_clk);
        end
        #1;
        n_chk++;
        if (t_md_timeout !== 1'b1 || t_dbg_state !== HZ_RUN || t_pv !== 5'b0) begin
            n_err++; $display("FAIL timeout_hit to=%b state=%0d pause=%b want 1/%0d/0", t_md_timeout, t_dbg_state, t_pv, HZ_RUN);
        end
        n_chk++;
        if (dbg_state !== HZ_MD_WAIT || md_timeout !== 1'b0) begin
            n_err++; $display("FAIL timeout_default state=%0d to=%b want %0d/0", dbg_state, md_timeout, HZ_MD_WAIT);
        end
        #2;
        core_rst_n = 1'b0;
        #1;
        n_chk++;
        if (dbg_state !== HZ_RUN || ev !== 4'b0 || t_md_timeout !== 1'b0 || pv !== 5'b0) begin
            n_err++; $display("FAIL async_reset state=%0d clk_en=%b to=%b pause=%b want %0d/0000/0/0",
                              dbg_state, ev, t_md_timeout, pv, HZ_RUN);
        end
        clr_inputs();
        @(negedge core_clk);
        core_rst_n = 1'b1;
        @(negedge core_clk);
        #1;
        n_chk++;
        if (ev !== 4'hf || dbg_state !== HZ_RUN) begin
            n_err++; $display("FAIL reset_recover clk_en=%b state=%0d want 1111/%0d", ev, dbg_state, HZ_RUN);
        end
    endtask

    initial begin
        clr_inputs();
        core_rst_n = 1'b0;
        test_reset();
        test_loaduse();
        test_md();
        test_lsu();
        test_branch_flush();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
